// File: rtl/adc_response_sink_pkg.sv
// Shared definitions for the ADC response sink.
//   state_e      : sequencer control FSM states
//   CMD_*        : sequencer CSR command address / data words
//   DRAIN_CYCLES : quiet cycles needed after a stop before going idle
package adc_response_sink_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        STOP  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    // Sequencer command register: bit 0 = run, bit 1 = mode (0 = continuous).
    localparam logic        CMD_ADDR     = 1'b0;
    localparam logic [31:0] CMD_RUN_CONT = 32'h0000_0001;
    localparam logic [31:0] CMD_STOP     = 32'h0000_0000;

    localparam int DRAIN_CYCLES = 16;
    localparam int DRAIN_CNT_W  = 5;

    // The sequencer is considered busy from the first RUN cycle until the
    // response stream has gone quiet after the stop command.
    function automatic logic is_running(state_e s);
        return (s == RUN) || (s == STOP) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/adc_ch_avg.sv
// Per-channel block averager: sums 2^AVG_LOG2 samples, then publishes the
// mean and raises a "new result" flag until the host reads it.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   beat_i        : a sample for this channel is present this cycle
//   data_i        : 12-bit sample
//   clr_new_i     : host read of this channel (clears new_o)
//   avg_o         : last completed average
//   new_o         : average not yet read by the host
module adc_ch_avg #(
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        beat_i,
    input  logic [11:0] data_i,
    input  logic        clr_new_i,
    output logic [11:0] avg_o,
    output logic        new_o
);

    // 12+AVG_LOG2 bits holds 2^AVG_LOG2 full-scale samples exactly.
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      avg_q, avg_d;
    logic             new_q, new_d;

    assign sum = acc_q + ACC_W'(data_i);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        avg_d = avg_q;
        new_d = new_q;
        // Clear first so a completing block in the same cycle wins.
        if (clr_new_i) begin
            new_d = 1'b0;
        end
        if (beat_i) begin
            if (cnt_q == CNT_LAST) begin
                avg_d = sum[ACC_W-1:AVG_LOG2];
                acc_d = '0;
                cnt_d = '0;
                new_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
            avg_q <= '0;
            new_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            avg_q <= avg_d;
            new_q <= new_d;
        end
    end

    assign avg_o = avg_q;
    assign new_o = new_q;

endmodule

// File: rtl/adc_response_sink.sv
// ADC response sink: starts/stops the ADC sequencer from a level enable,
// averages the response stream per channel, tracks framing, and serves
// results to a host read port.
//   clk_clk, reset_reset_n        : clock, asynchronous active-low reset
//   enable                        : level request to run the sequencer
//   adc_sequencer_csr_*           : sequencer CSR master (write-only use)
//   adc_response_*                : response stream sink
//   host_addr/read/rdata          : registered result read port
//   running, frame_count, drop_count, frame_err : status
//   dbg_state_o                   : current control FSM state
//
// Stream handshake: the response stream has valid but no ready; a beat is
// transferred on every rising clk_clk edge where adc_response_valid is 1,
// regardless of FSM state, and can never be stalled.
module adc_response_sink
    import adc_response_sink_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    output logic        adc_sequencer_csr_address,
    output logic        adc_sequencer_csr_read,
    output logic        adc_sequencer_csr_write,
    output logic [31:0] adc_sequencer_csr_writedata,
    input  logic [31:0] adc_sequencer_csr_readdata,
    input  logic        adc_response_valid,
    input  logic [4:0]  adc_response_channel,
    input  logic [11:0] adc_response_data,
    input  logic        adc_response_startofpacket,
    input  logic        adc_response_endofpacket,
    input  logic [3:0]  host_addr,
    input  logic        host_read,
    output logic [15:0] host_rdata,
    output logic        running,
    output logic [15:0] frame_count,
    output logic [7:0]  drop_count,
    output logic        frame_err,
    output logic [2:0]  dbg_state_o
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [15:0]            frame_count_q, frame_count_d;
    logic [7:0]             drop_count_q, drop_count_d;
    logic                   frame_err_q, frame_err_d;
    logic                   in_frame_q, in_frame_d;
    logic [15:0]            host_rdata_q, host_rdata_d;
    logic                   beat_dropped;

    // Results padded to 16 slots so any host_addr indexes safely; unused
    // slots read as zero.
    logic [15:0][11:0] avg_all;
    logic [15:0]       new_all;

    // Readback is not used; the sequencer is only ever commanded.
    logic unused_readdata;
    assign unused_readdata = ^adc_sequencer_csr_readdata;

    assign beat_dropped = adc_response_valid && (adc_response_channel >= 5'(NUM_CH));

    for (genvar i = 0; i < 16; i++) begin : g_ch
        if (i < NUM_CH) begin : g_used
            adc_ch_avg #(
                .AVG_LOG2 (AVG_LOG2)
            ) u_avg (
                .clk_i     (clk_clk),
                .rst_ni    (reset_reset_n),
                .beat_i    (adc_response_valid && (adc_response_channel == 5'(i))),
                .data_i    (adc_response_data),
                .clr_new_i (host_read && (host_addr == 4'(i))),
                .avg_o     (avg_all[i]),
                .new_o     (new_all[i])
            );
        end else begin : g_empty
            assign avg_all[i] = 12'h000;
            assign new_all[i] = 1'b0;
        end
    end

    // Control FSM. START and STOP each last exactly one cycle, so a change
    // of enable during them is only seen once RUN/IDLE re-evaluate it.
    always_comb begin
        state_d                     = state_q;
        drain_cnt_d                 = drain_cnt_q;
        adc_sequencer_csr_write     = 1'b0;
        adc_sequencer_csr_writedata = 32'h0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = START;
                end
            end
            START: begin
                adc_sequencer_csr_write     = 1'b1;
                adc_sequencer_csr_writedata = CMD_RUN_CONT;
                state_d                     = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                adc_sequencer_csr_write     = 1'b1;
                adc_sequencer_csr_writedata = CMD_STOP;
                drain_cnt_d                 = '0;
                state_d                     = DRAIN;
            end
            DRAIN: begin
                // Counts consecutive quiet cycles; any beat restarts it.
                if (adc_response_valid) begin
                    drain_cnt_d = '0;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    drain_cnt_d = '0;
                    state_d     = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status counters, framing check and host read capture.
    always_comb begin
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        frame_err_d   = frame_err_q;
        in_frame_d    = in_frame_q;
        host_rdata_d  = host_rdata_q;
        if (adc_response_valid) begin
            if (adc_response_endofpacket) begin
                frame_count_d = frame_count_q + 16'd1;
            end
            if (beat_dropped && (drop_count_q != 8'hFF)) begin
                drop_count_d = drop_count_q + 8'd1;
            end
            // sop+eop together is a legal one-beat frame, so an eop only
            // errors when it has no frame to close and starts none itself.
            if ((adc_response_startofpacket && in_frame_q) ||
                (adc_response_endofpacket && !adc_response_startofpacket && !in_frame_q)) begin
                frame_err_d = 1'b1;
            end
            if (adc_response_endofpacket) begin
                in_frame_d = 1'b0;
            end else if (adc_response_startofpacket) begin
                in_frame_d = 1'b1;
            end
        end
        if (host_read) begin
            host_rdata_d = {new_all[host_addr], 3'b000, avg_all[host_addr]};
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            drain_cnt_q   <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            frame_err_q   <= 1'b0;
            in_frame_q    <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            frame_err_q   <= frame_err_d;
            in_frame_q    <= in_frame_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    assign adc_sequencer_csr_address = CMD_ADDR;
    assign adc_sequencer_csr_read    = 1'b0;
    assign host_rdata                = host_rdata_q;
    assign running                   = is_running(state_q);
    assign frame_count               = frame_count_q;
    assign drop_count                = drop_count_q;
    assign frame_err                 = frame_err_q;
    assign dbg_state_o               = state_q;

endmodule
